// File: rtl/mdu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the MDU issue sequencer in the E stage:
//   - MDU op-code constants (4-bit encoding, codes 9..15 behave as NONE)
//   - classification helpers used by the controller
//   - FSM state encoding
// Optional build macro used by files importing this package:
//   MDU_FLUSH_ABORT_EN (see mdu_issue_ctrl.sv)
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t OP_NONE  = 4'd0;
    localparam mdu_op_t OP_MULT  = 4'd1;
    localparam mdu_op_t OP_MULTU = 4'd2;
    localparam mdu_op_t OP_DIV   = 4'd3;
    localparam mdu_op_t OP_DIVU  = 4'd4;
    localparam mdu_op_t OP_MTHI  = 4'd5;
    localparam mdu_op_t OP_MTLO  = 4'd6;
    localparam mdu_op_t OP_MFHI  = 4'd7;
    localparam mdu_op_t OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    // Any instruction that touches HI/LO and therefore must wait for an
    // in-flight operation (MULT..MFLO).
    function automatic logic is_mdu_op(input mdu_op_t op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

    // Instructions that launch a multi-cycle datapath operation.
    function automatic logic is_muldiv_op(input mdu_op_t op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_mult_op(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_issue_if
// Handshake bundle between the E-stage pipeline and the MDU issue
// controller.
//   req_valid, req_op, flush       : pipeline -> controller
//   start, start_op                : controller -> datapath launch
//   hi_we, lo_we                   : MTHI / MTLO write enables
//   result_we                      : datapath {HI,LO} commit strobe
//   busy, stall                    : status / pipeline freeze
// modport master : pipeline side (drives the request)
// modport slave  : controller side
// ---------------------------------------------------------------------------
interface mdu_issue_if;
    import mdu_pkg::*;

    logic    req_valid;
    mdu_op_t req_op;
    logic    flush;
    logic    start;
    mdu_op_t start_op;
    logic    hi_we;
    logic    lo_we;
    logic    result_we;
    logic    busy;
    logic    stall;

    modport master (
        output req_valid, req_op, flush,
        input  start, start_op, hi_we, lo_we, result_we, busy, stall
    );

    modport slave (
        input  req_valid, req_op, flush,
        output start, start_op, hi_we, lo_we, result_we, busy, stall
    );

endinterface

// File: rtl/mdu_lat_counter.sv
// ---------------------------------------------------------------------------
// mdu_lat_counter
// Latency down-counter for the MDU sequencer. Loads the operation latency on
// issue, decrements while the operation is in flight and flags the final
// (commit) cycle when the count equals 1.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clear      : synchronous clear (abort path)
//   load       : load load_val (takes priority over dec)
//   load_val   : latency to load
//   dec        : decrement by one (saturates at 0)
//   last       : count == 1
// ---------------------------------------------------------------------------
module mdu_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Counter register: clear beats load, load beats decrement. The
    // decrement saturates so a stray dec after expiry cannot wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
// Sequencer for the multiply/divide unit in the E stage of the 5-stage MIPS
// pipeline. Issues MULT/MULTU/DIV/DIVU to the datapath with a one-cycle
// start strobe, times the latency, strobes the {HI,LO} commit and stalls
// any HI/LO-touching instruction while an operation is in flight (commit
// cycle included, so MFHI/MFLO never observe stale values).
// Parameters:
//   MULT_LAT : issue-to-commit cycles for MULT/MULTU (>=1)
//   DIV_LAT  : issue-to-commit cycles for DIV/DIVU (>=1)
//   CNT_W    : counter width, must hold max(MULT_LAT, DIV_LAT)
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : mdu_issue_if.slave (request, strobes, busy, stall)
// Build option:
//   MDU_FLUSH_ABORT_EN : when defined, a flush while BUSY aborts the
//   in-flight operation (no commit, HI/LO keep their old values). When
//   undefined, flush while BUSY is ignored and the operation commits.
// ---------------------------------------------------------------------------
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input logic        clk,
    input logic        reset,
    mdu_issue_if.slave bus
);

    mdu_state_t       state;
    mdu_state_t       state_next;

    logic             accept;
    logic             abort;
    logic             cnt_last;
    logic             cnt_load;
    logic             cnt_clear;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;

    logic             start;
    mdu_op_t          start_op;
    logic             hi_we;
    logic             lo_we;
    logic             result_we;
    logic             stall;

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output logic. Stall is sourced only from BUSY, so a
    // start can never coincide with a stall. The write strobes are masked
    // during reset so a request arriving in the reset cycle has no effect.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_clear    = 1'b0;
        cnt_dec      = 1'b0;
        start        = 1'b0;
        start_op     = OP_NONE;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        result_we    = 1'b0;

`ifdef MDU_FLUSH_ABORT_EN
        abort = bus.flush;
`else
        abort = 1'b0;
`endif

        stall  = (state == BUSY) && bus.req_valid && is_mdu_op(bus.req_op);
        accept = bus.req_valid && !bus.flush && !stall;

        case (state)
            IDLE: begin
                if (accept && !reset) begin
                    if (is_mult_op(bus.req_op)) begin
                        start        = 1'b1;
                        start_op     = bus.req_op;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MULT_LAT);
                        state_next   = BUSY;
                    end else if (is_div_op(bus.req_op)) begin
                        start        = 1'b1;
                        start_op     = bus.req_op;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DIV_LAT);
                        state_next   = BUSY;
                    end else if (bus.req_op == OP_MTHI) begin
                        hi_we = 1'b1;
                    end else if (bus.req_op == OP_MTLO) begin
                        lo_we = 1'b1;
                    end
                end
            end

            BUSY: begin
                if (abort) begin
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        result_we  = !reset;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.start     = start;
    assign bus.start_op  = start_op;
    assign bus.hi_we     = hi_we;
    assign bus.lo_we     = lo_we;
    assign bus.result_we = result_we;
    assign bus.busy      = (state == BUSY);
    assign bus.stall     = stall;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
// Self-checking bench for mdu_issue_ctrl. A behavioural model tracks the
// number of cycles remaining until commit and derives every output from
// the instruction-level rules. Directed sequences cover the issue, stall,
// commit-cycle, flush and reset scenarios; a randomized run follows.
// Honours MDU_FLUSH_ABORT_EN to select the flush-while-busy behaviour.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int errors    = 0;
    int checks    = 0;
    int remaining = 0;

    mdu_issue_if bus ();

    mdu_issue_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check all outputs against the model, then
    // advance the model across the rising edge. Checks are skipped while
    // reset is asserted; the following cycle verifies the reset state.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic fl, input logic rst);
        logic in_flight;
        logic e_stall, e_start, e_hi, e_lo, e_res, abort_now;
        logic [3:0] e_op;
        int op_i;

        @(negedge clk);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.flush     = fl;
        reset         = rst;
        #1;

        op_i      = int'(op);
        in_flight = (remaining > 0);
`ifdef MDU_FLUSH_ABORT_EN
        abort_now = in_flight && fl;
`else
        abort_now = 1'b0;
`endif
        e_stall = in_flight && v && (op_i >= 1) && (op_i <= 8);
        e_start = !in_flight && v && !fl && (op_i >= 1) && (op_i <= 4);
        e_op    = e_start ? op : 4'd0;
        e_hi    = !in_flight && v && !fl && (op_i == 5);
        e_lo    = !in_flight && v && !fl && (op_i == 6);
        e_res   = in_flight && (remaining == 1) && !abort_now;

        if (!rst) begin
            checkOutput("start",     32'(bus.start),     32'(e_start));
            checkOutput("start_op",  32'(bus.start_op),  32'(e_op));
            checkOutput("hi_we",     32'(bus.hi_we),     32'(e_hi));
            checkOutput("lo_we",     32'(bus.lo_we),     32'(e_lo));
            checkOutput("result_we", 32'(bus.result_we), 32'(e_res));
            checkOutput("busy",      32'(bus.busy),      32'(in_flight));
            checkOutput("stall",     32'(bus.stall),     32'(e_stall));
        end

        @(posedge clk);
        if (rst) begin
            remaining = 0;
        end else if (in_flight) begin
            remaining = abort_now ? 0 : remaining - 1;
        end else if (e_start) begin
            remaining = (op_i <= 2) ? MULT_LAT : DIV_LAT;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.flush     = 1'b0;

        // Reset and check the idle state.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // MULT latency and commit timing.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // DIVU followed by a dependent MFLO that stalls until the op is done.
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // MTHI arriving in the commit cycle is held off by one cycle.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // Flushed issue: DIV and MTLO are killed.
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // Flush in the middle of a MULT.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset mid-DIV, then an immediate MULT.
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset landing exactly in a commit cycle.
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < MULT_LAT - 1; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);

        // Randomized traffic including out-of-range op codes.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(
                ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0
            );
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
